lsu_mem_if: RTL

- Parametrised load/store unit between the execute stage and the data memory port of the pipelined rv32i core.
- Accepts one load or store per transaction and runs it as a registered request/valid handshake with the memory.
- Generates byte masks and lane alignment, and sign/zero-extends load data.
- Stalls the pipeline while a transaction is outstanding and aborts it with a bus error on timeout.

---
 rtl/lsu_pkg.sv | 30 +++
 rtl/lsu_align.sv | 61 ++++++
 rtl/lsu_mem_if.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared types, funct3 encodings and access-size decoding for the rv32i/rv64i load/store unit.
package lsu_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_D  = 3'b011;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;
    localparam logic [2:0] F3_WU = 3'b110;

    // Doubleword encodings collapse to a word access on a 32-bit datapath.
    function automatic logic [3:0] size_bytes(input logic [2:0] funct3, input int data_width);
        logic [3:0] size;
        case (funct3[1:0])
            2'b00:   size = 4'd1;
            2'b01:   size = 4'd2;
            2'b10:   size = 4'd4;
            2'b11:   size = (data_width == 64) ? 4'd8 : 4'd4;
            default: size = 4'd4;
        endcase
        return size;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane datapath: store byte enables and lane shift, load lane shift and sign/zero extension.
module lsu_align
    import lsu_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int OffW      = $clog2(DataWidth / 8)
) (
    input  logic [3:0]             st_size,
    input  logic [OffW-1:0]        st_offset,
    input  logic [DataWidth-1:0]   store_data,
    output logic [DataWidth/8-1:0] mask,
    output logic [DataWidth-1:0]   wdata,
    input  logic [3:0]             ld_size,
    input  logic                   ld_signed,
    input  logic [OffW-1:0]        ld_offset,
    input  logic [DataWidth-1:0]   rdata,
    output logic [DataWidth-1:0]   load_data
);
    localparam int NB   = DataWidth / 8;
    localparam int IdxW = $clog2(DataWidth);

    logic [DataWidth-1:0] shifted_s;
    logic [6:0]           msb_full_s;
    logic [IdxW-1:0]      msb_idx_s;
    logic                 fill_s;

    assign wdata = store_data << {st_offset, 3'b000};

    // Byte enables cover offset .. offset+size-1.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NB; i++) begin
            if ((i >= int'(st_offset)) && (i < int'(st_offset) + int'(st_size))) begin
                mask[i] = 1'b1;
            end else begin
                mask[i] = 1'b0;
            end
        end
    end

    // Bring the addressed lane down to bit 0, then extend above the access size.
    always_comb begin
        shifted_s  = rdata >> {ld_offset, 3'b000};
        msb_full_s = {ld_size, 3'b000} - 7'd1;
        msb_idx_s  = msb_full_s[IdxW-1:0];
        if (ld_signed) begin
            fill_s = shifted_s[msb_idx_s];
        end else begin
            fill_s = 1'b0;
        end
        load_data = '0;
        for (int i = 0; i < DataWidth; i++) begin
            if (i <= int'(msb_idx_s)) begin
                load_data[i] = shifted_s[i];
            end else begin
                load_data[i] = fill_s;
            end
        end
    end

endmodule

// File: rtl/lsu_mem_if.sv
// Load/store unit: request/valid memory handshake, pipeline stall, timeout abort.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned accesses instead of truncating them.
module lsu_mem_if
    import lsu_pkg::*;
#(
    parameter int DataWidth     = 32,
    parameter int RegAddress    = 5,
    parameter int TimeoutCycles = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic                   store,
    input  logic [2:0]             funct3,
    input  logic [DataWidth-1:0]   address,
    input  logic [DataWidth-1:0]   store_data,
    input  logic [RegAddress-1:0]  rd_in,
    input  logic                   mem_valid,
    input  logic [DataWidth-1:0]   mem_rdata,
    output logic                   mem_request,
    output logic                   mem_we_re,
    output logic [DataWidth/8-1:0] mem_mask,
    output logic [DataWidth-1:0]   mem_address,
    output logic [DataWidth-1:0]   mem_wdata,
    output logic                   stall,
    output logic                   wb_valid,
    output logic [RegAddress-1:0]  wb_rd,
    output logic [DataWidth-1:0]   wb_data,
    output logic                   bus_error,
    output logic                   misaligned
);
    localparam int NB   = DataWidth / 8;
    localparam int OffW = $clog2(NB);
    localparam int CntW = $clog2(TimeoutCycles) + 1;

    lsu_state_e            state_r;
    lsu_state_e            state_s;
    logic [CntW-1:0]       count_r;
    logic [2:0]            funct3_r;
    logic [OffW-1:0]       offset_r;
    logic                  is_load_r;
    logic [RegAddress-1:0] rd_r;

    logic                  strobe_s;
    logic                  mis_s;
    logic                  issue_s;
    logic                  done_s;
    logic                  abort_s;
    logic [3:0]            size_s;
    logic [3:0]            ld_size_s;
    logic [OffW-1:0]       size_m1_s;
    logic [OffW-1:0]       raw_off_s;
    logic [OffW-1:0]       off_s;
    logic                  ld_signed_s;
    logic [NB-1:0]         mask_s;
    logic [DataWidth-1:0]  wdata_s;
    logic [DataWidth-1:0]  load_data_s;

    assign strobe_s    = load | store;
    assign size_s      = size_bytes(funct3, DataWidth);
    assign size_m1_s   = OffW'(size_s - 4'd1);
    assign raw_off_s   = address[OffW-1:0];
    assign ld_size_s   = size_bytes(funct3_r, DataWidth);
    assign ld_signed_s = ~funct3_r[2];

`ifdef LSU_MISALIGN_TRAP_EN
    assign off_s = raw_off_s;
    assign mis_s = |(raw_off_s & size_m1_s);
`else
    // Without the trap, the low offset bits below the access size are simply dropped.
    assign off_s = raw_off_s & ~size_m1_s;
    assign mis_s = 1'b0;
`endif

    lsu_align #(
        .DataWidth (DataWidth)
    ) u_align (
        .st_size    (size_s),
        .st_offset  (off_s),
        .store_data (store_data),
        .mask       (mask_s),
        .wdata      (wdata_s),
        .ld_size    (ld_size_s),
        .ld_signed  (ld_signed_s),
        .ld_offset  (offset_r),
        .rdata      (mem_rdata),
        .load_data  (load_data_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (issue_s) begin
                    state_s = BUSY;
                end else begin
                    state_s = IDLE;
                end
            end
            BUSY: begin
                if (done_s | abort_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = BUSY;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // Handshake decode; mem_valid takes priority over the timeout in the same cycle.
    always_comb begin
        issue_s = 1'b0;
        done_s  = 1'b0;
        abort_s = 1'b0;
        stall   = 1'b0;
        case (state_r)
            IDLE: begin
                issue_s = strobe_s & ~mis_s;
                stall   = strobe_s & ~mis_s;
            end
            BUSY: begin
                done_s  = mem_valid;
                abort_s = ~mem_valid & (count_r == CntW'(TimeoutCycles - 1));
                stall   = 1'b1;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

    // Timeout counter: cleared on issue, counts BUSY cycles without completion.
    always_ff @(posedge clk) begin
        if (!rst) begin
            count_r <= '0;
        end else if (issue_s) begin
            count_r <= '0;
        end else if ((state_r == BUSY) && !mem_valid) begin
            count_r <= count_r + CntW'(1);
        end else begin
            count_r <= count_r;
        end
    end

    // Transaction context needed when the load data returns.
    always_ff @(posedge clk) begin
        if (!rst) begin
            funct3_r  <= 3'b000;
            offset_r  <= '0;
            is_load_r <= 1'b0;
            rd_r      <= '0;
        end else if (issue_s) begin
            funct3_r  <= funct3;
            offset_r  <= off_s;
            is_load_r <= load;
            rd_r      <= rd_in;
        end else begin
            funct3_r  <= funct3_r;
            offset_r  <= offset_r;
            is_load_r <= is_load_r;
            rd_r      <= rd_r;
        end
    end

    // Memory-side outputs stay stable for the whole BUSY period.
    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_request <= 1'b0;
            mem_we_re   <= 1'b0;
            mem_mask    <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
        end else if (issue_s) begin
            mem_request <= 1'b1;
            mem_we_re   <= ~load;
            mem_mask    <= mask_s;
            mem_address <= {address[DataWidth-1:OffW], {OffW{1'b0}}};
            mem_wdata   <= wdata_s;
        end else if (done_s | abort_s) begin
            mem_request <= 1'b0;
        end else begin
            mem_request <= mem_request;
        end
    end

    // Writeback and error pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wb_valid  <= 1'b0;
            wb_rd     <= '0;
            wb_data   <= '0;
            bus_error <= 1'b0;
        end else begin
            wb_valid  <= done_s & is_load_r;
            bus_error <= abort_s;
            if (done_s & is_load_r) begin
                wb_rd   <= rd_r;
                wb_data <= load_data_s;
            end else begin
                wb_rd   <= wb_rd;
                wb_data <= wb_data;
            end
        end
    end

`ifdef LSU_MISALIGN_TRAP_EN
    // Misalignment pulse for a strobe that was refused in IDLE.
    always_ff @(posedge clk) begin
        if (!rst) begin
            misaligned <= 1'b0;
        end else begin
            misaligned <= (state_r == IDLE) & strobe_s & mis_s;
        end
    end
`else
    assign misaligned = 1'b0;
`endif

endmodule
